// File: rtl/lcm_seq_if.sv
// rtl/lcm_seq_if.sv - request/result bundle between an LCM/HCF requester and lcm_seq
interface lcm_seq_if #(
  parameter int N = 8
);
  logic           start;
  logic [N-1:0]   in1;
  logic [N-1:0]   in2;
  logic           busy;
  logic           done;
  logic [N-1:0]   hcf;
  logic [2*N-1:0] lcm;

  modport master (output start, in1, in2, input busy, done, hcf, lcm);
  modport slave  (input start, in1, in2, output busy, done, hcf, lcm);
endinterface

// File: rtl/lcm_seq.sv
// rtl/lcm_seq.sv - sequential HCF/LCM: subtractive GCD, restoring divide, shift-add multiply
module lcm_seq #(
  parameter int N = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  lcm_seq_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GCD  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   x_q, x_d;
  logic [N-1:0]   y_q, y_d;
  logic [N-1:0]   g_q, g_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [2*N-1:0] p_q, p_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   hcf_q, hcf_d;
  logic [2*N-1:0] lcm_q, lcm_d;

  logic [N:0]     div_shift;
  logic [N:0]     div_diff;
  logic           div_fits;
  logic [2*N-1:0] mul_sum;
  logic           last_step;

  // rem < g always holds, so the sign bit of the trial subtraction is a clean borrow
  assign div_shift = {rem_q, quo_q[N-1]};
  assign div_diff  = div_shift - {1'b0, g_q};
  assign div_fits  = ~div_diff[N];
  assign mul_sum   = (p_q << 1) + (quo_q[N-1] ? {{N{1'b0}}, b_q} : {(2*N){1'b0}});
  assign last_step = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    y_d     = y_q;
    g_d     = g_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    hcf_d   = hcf_q;
    lcm_d   = lcm_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d = bus.in1;
          b_d = bus.in2;
          x_d = bus.in1;
          y_d = bus.in2;
          if (bus.in1 == '0 || bus.in2 == '0) begin
            hcf_d   = bus.in1 | bus.in2;
            lcm_d   = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_GCD;
          end
        end
      end
      S_GCD: begin
        if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else if (y_q > x_q) begin
          y_d = y_q - x_q;
        end else begin
          g_d     = x_q;
          rem_d   = '0;
          quo_d   = a_q;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = div_fits ? div_diff[N-1:0] : div_shift[N-1:0];
        quo_d = {quo_q[N-2:0], div_fits};
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          cnt_d   = '0;
          p_d     = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        // quotient is consumed MSB first as the multiplier
        p_d   = mul_sum;
        quo_d = {quo_q[N-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          cnt_d   = '0;
          hcf_d   = g_q;
          lcm_d   = mul_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      g_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      hcf_q   <= '0;
      lcm_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      g_q     <= g_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      hcf_q   <= hcf_d;
      lcm_q   <= lcm_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.hcf  = hcf_q;
  assign bus.lcm  = lcm_q;
endmodule

// File: doc/lcm_seq.md
LCM_SEQ -- requirements
Module: lcm_seq

Interface
REQ-001 Parameter N, default 8: operand width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request pulse, sampled only in IDLE.
REQ-005 in1  input  N  first operand, unsigned, sampled on accepted start.
REQ-006 in2  input  N  second operand, unsigned, sampled on accepted start.
REQ-007 busy  output  1  high in every state other than IDLE.
REQ-008 done  output  1  one-cycle pulse marking valid results.
REQ-009 hcf  output  N  greatest common divisor of the captured operands.
REQ-010 lcm  output  2N  least common multiple of the captured operands.

Function
REQ-011 The FSM SHALL have exactly five states: IDLE, GCD, DIV, MUL and DONE.
REQ-012 In IDLE, a start sampled high SHALL capture in1 into register A and in2 into register B.
REQ-013 On that capture, if A=0 or B=0 the FSM SHALL go to DONE; otherwise it SHALL go to GCD with x=A, y=B.
REQ-014 Zero-operand results SHALL be lcm=0 and hcf=A|B, so (0,0) gives hcf=0 and lcm=0.
REQ-015 In GCD, each cycle SHALL perform exactly one action:
- if x>y: x<=x-y
- if y>x: y<=y-x
- if x=y: g<=x and go to DIV.
REQ-016 DIV SHALL take exactly N cycles of restoring division computing q=A/g; the remainder is always 0 and is discarded.
REQ-017 MUL SHALL take exactly N cycles of shift-add multiplication computing p=q*B with 2N-bit width; no overflow is possible since p<=A*B.
REQ-018 DONE SHALL last one cycle: hcf<=g, lcm<=p, done=1, then the FSM returns to IDLE.
REQ-019 Latency for nonzero operands:
- let k = number of subtraction cycles + 1
- done SHALL be high in cycle k+2N+1 counted from the edge that samples start.
REQ-020 Latency for a zero operand: done SHALL be high in cycle 1 after the sampling edge.
REQ-021 start while busy=1 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-022 in1/in2 changes after capture SHALL NOT affect the operation in flight.
REQ-023 hcf and lcm SHALL hold their values from the last DONE until the next DONE.
REQ-024 start held high continuously SHALL begin a new operation in the cycle after DONE; back-to-back operations SHALL have no dead cycle other than the IDLE cycle.
REQ-025 done SHALL never be high for two consecutive cycles.
REQ-026 busy SHALL be high from the cycle after an accepted start through the DONE cycle inclusive.

Reset
REQ-027 rst_n low SHALL immediately force IDLE and set busy=0, done=0, hcf=0, lcm=0, with all internal registers cleared.
REQ-028 Reset asserted mid-operation SHALL abort the operation; no done pulse is produced for it.
REQ-029 After rst_n deasserts, the first start SHALL be accepted at the next rising edge.

Verification
REQ-030 Nominal case: in1=27, in2=45 with a start pulse -> hcf=9, lcm=135, k=4, done in cycle 21 (N=8).
REQ-031 Sequential operations: (56,84) then (17,103) -> hcf=28/lcm=168, then hcf=1/lcm=1751; outputs hold between done pulses.
REQ-032 Zero and maximum-length cases:
- (0,45) -> hcf=45, lcm=0, done in cycle 1
- (255,254) -> hcf=1, lcm=64770, k=255, done in cycle 272.
REQ-033 Busy-start and operand stability: during (108,24), pulse start with (100,70) and toggle in1/in2 while busy -> ignored; result hcf=12, lcm=216.
REQ-034 Reset abort: assert rst_n low during DIV of (49,77) -> outputs 0 and busy=0 immediately, no done pulse; a following (100,70) gives hcf=10, lcm=700.
REQ-035 The bench SHALL compare every result against a reference model over at least 1000 random operand pairs, including zeros and equal operands (x=y gives k=1).
